// File: rtl/seg7_readback_decoder.sv
// Receive side of the 7-segment display path: synchronises and debounces a segment
// bus, decodes each stable glyph back to a hex digit and checks the counter step.
//
// state  | meaning
// IDLE   | after reset; waiting for seg_s to move away from 0
// SETTLE | new pattern seen; counting stable cycles before acceptance
// LOCKED | current pattern accepted; hold until seg_s changes
module seg7_readback_decoder #(
  parameter int         STABLE_CYCLES = 4,
  parameter logic [3:0] STEP          = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       blank,
  output logic       glyph_err,
  output logic       seq_err,
  output logic [7:0] err_cnt
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [6:0]    s1, seg_s;
  logic [6:0]    cand, cand_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic          have_prev, have_prev_nxt;
  logic [3:0]    digit_nxt;
  logic          digit_valid_nxt, blank_nxt, glyph_err_nxt, seq_err_nxt;
  logic [7:0]    err_cnt_nxt;
  logic [4:0]    dec;
  logic [3:0]    step_exp;

  // {valid, value}; pattern 0 is handled separately as blank
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: return {1'b1, 4'h0};
      7'h06: return {1'b1, 4'h1};
      7'h5B: return {1'b1, 4'h2};
      7'h4F: return {1'b1, 4'h3};
      7'h66: return {1'b1, 4'h4};
      7'h6D: return {1'b1, 4'h5};
      7'h7D: return {1'b1, 4'h6};
      7'h07: return {1'b1, 4'h7};
      7'h7F: return {1'b1, 4'h8};
      7'h6F: return {1'b1, 4'h9};
      7'h77: return {1'b1, 4'hA};
      7'h7C: return {1'b1, 4'hB};
      7'h39: return {1'b1, 4'hC};
      7'h5E: return {1'b1, 4'hD};
      7'h79: return {1'b1, 4'hE};
      7'h71: return {1'b1, 4'hF};
      default: return 5'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      seg_s <= '0;
    end else begin
      s1    <= seg_in;
      seg_s <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cand starts at 0, so IDLE is only left once seg_s becomes nonzero
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (seg_s != cand) begin
      cand_nxt  = seg_s;
      cnt_nxt   = '0;
      state_nxt = SETTLE;
    end else if (state == SETTLE) begin
      if (cnt == CNT_LAST) begin
        state_nxt = LOCKED;
        accept    = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // digit doubles as the previous value: have_prev is only set by a valid glyph
  always_comb begin
    dec             = decode(cand);
    step_exp        = digit + STEP;
    digit_nxt       = digit;
    digit_valid_nxt = 1'b0;
    blank_nxt       = blank;
    glyph_err_nxt   = 1'b0;
    seq_err_nxt     = 1'b0;
    have_prev_nxt   = have_prev;
    err_cnt_nxt     = err_cnt;
    if (accept) begin
      if (cand == 7'h00) begin
        blank_nxt     = 1'b1;
        have_prev_nxt = 1'b0;
      end else if (dec[4]) begin
        digit_nxt       = dec[3:0];
        digit_valid_nxt = 1'b1;
        blank_nxt       = 1'b0;
        seq_err_nxt     = have_prev && (dec[3:0] != step_exp);
        have_prev_nxt   = 1'b1;
      end else begin
        glyph_err_nxt = 1'b1;
        have_prev_nxt = 1'b0;
      end
    end
    if (clr) begin
      err_cnt_nxt   = '0;
      have_prev_nxt = 1'b0;
    end else if ((glyph_err_nxt || seq_err_nxt) && (err_cnt != 8'hFF)) begin
      err_cnt_nxt = err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit       <= '0;
      digit_valid <= 1'b0;
      blank       <= 1'b0;
      glyph_err   <= 1'b0;
      seq_err     <= 1'b0;
      err_cnt     <= '0;
      have_prev   <= 1'b0;
    end else begin
      digit       <= digit_nxt;
      digit_valid <= digit_valid_nxt;
      blank       <= blank_nxt;
      glyph_err   <= glyph_err_nxt;
      seq_err     <= seq_err_nxt;
      err_cnt     <= err_cnt_nxt;
      have_prev   <= have_prev_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Bench for seg7_readback_decoder: directed sequences plus random glyph episodes,
// checked every cycle against a sample-window reference model.
module tb_seg7_readback_decoder;

  localparam int S = 4;
  localparam int STEP = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       clr;
  logic [3:0] digit;
  logic       digit_valid, blank, glyph_err, seq_err;
  logic [7:0] err_cnt;

  seg7_readback_decoder #(.STABLE_CYCLES(S), .STEP(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .clr(clr),
    .digit(digit), .digit_valid(digit_valid), .blank(blank),
    .glyph_err(glyph_err), .seq_err(seq_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int dv_seen = 0, se_seen = 0, ge_seen = 0;

  logic [6:0] glyph [16];

  // model: h[k] is the seg_in sample taken k edges ago
  int h [S+4];
  int m_digit, m_dv, m_blank, m_ge, m_se, m_err, m_prev, m_have_prev;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] dig;
  } vec_t;
  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int lookup(input int p);
    for (int i = 0; i < 16; i++)
      if (int'(glyph[i]) == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < S + 4; k++) h[k] = 0;
    m_digit = 0; m_dv = 0; m_blank = 0; m_ge = 0; m_se = 0; m_err = 0;
    m_prev = 0; m_have_prev = 0;
  endtask

  task automatic model_edge(input int sample, input bit c);
    bit acc;
    int v, idx;
    for (int k = S + 3; k > 0; k--) h[k] = h[k-1];
    h[0] = sample;
    v = h[2];
    acc = (h[S+3] != v);
    for (int k = 2; k <= S + 2; k++) if (h[k] != v) acc = 0;
    m_dv = 0; m_ge = 0; m_se = 0;
    if (acc) begin
      idx = lookup(v);
      if (v == 0) begin
        m_blank = 1; m_have_prev = 0;
      end else if (idx >= 0) begin
        m_se = (m_have_prev != 0 && idx != (m_prev + STEP) % 16) ? 1 : 0;
        m_digit = idx; m_dv = 1; m_blank = 0;
        m_prev = idx; m_have_prev = 1;
      end else begin
        m_ge = 1; m_have_prev = 0;
      end
    end
    if (c) begin
      m_err = 0; m_have_prev = 0;
    end else if ((m_ge != 0 || m_se != 0) && m_err < 255) begin
      m_err++;
    end
  endtask

  task automatic compare();
    chk("digit", 32'(digit), 32'(m_digit));
    chk("digit_valid", 32'(digit_valid), 32'(m_dv));
    chk("blank", 32'(blank), 32'(m_blank));
    chk("glyph_err", 32'(glyph_err), 32'(m_ge));
    chk("seq_err", 32'(seq_err), 32'(m_se));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(int'(seg_in), clr);
    #1;
    compare();
    if (digit_valid) dv_seen++;
    if (seq_err) se_seen++;
    if (glyph_err) ge_seen++;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) step();
  endtask

  task automatic measure(input logic [6:0] p, output int n);
    seg_in = p;
    n = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (digit_valid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, d0, s0, g0, last;
    logic [6:0] p;

    glyph[0] = 7'h3F; glyph[1] = 7'h06; glyph[2] = 7'h5B; glyph[3] = 7'h4F;
    glyph[4] = 7'h66; glyph[5] = 7'h6D; glyph[6] = 7'h7D; glyph[7] = 7'h07;
    glyph[8] = 7'h7F; glyph[9] = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
    glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;
    for (int i = 0; i < 16; i++) begin
      vecs[i].seg = glyph[15 - i];
      vecs[i].dig = 4'(15 - i);
    end
    vecs[16].seg = 7'h71;
    vecs[16].dig = 4'hF;

    rst_n = 1'b0; seg_in = 7'h00; clr = 1'b0;
    #2;
    model_reset();
    compare();
    repeat (3) step();
    rst_n = 1'b1;
    hold(7'h00, 8);

    // 1: latency from first sample edge to strobe
    measure(7'h06, n);
    chk("t1_latency", 32'(n), 32'd6);
    chk("t1_digit", 32'(digit), 32'd1);
    chk("t1_seq_err", 32'(seq_err), 32'd0);
    hold(7'h06, 4);

    // 2: count down F..0,F after a blank clears history
    hold(7'h00, 10);
    d0 = dv_seen; s0 = se_seen;
    for (int i = 0; i < 17; i++) begin
      hold(vecs[i].seg, 10);
      chk("t2_digit", 32'(digit), 32'(vecs[i].dig));
    end
    chk("t2_pulses", 32'(dv_seen - d0), 32'd17);
    chk("t2_seq_errs", 32'(se_seen - s0), 32'd0);
    chk("t2_err_cnt", 32'(err_cnt), 32'd0);

    // 3: skipped step
    hold(7'h00, 10);
    hold(7'h3F, 10);
    measure(7'h4F, n);
    chk("t3_seq_err", 32'(seq_err), 32'd1);
    chk("t3_digit", 32'(digit), 32'd3);
    chk("t3_err_cnt", 32'(err_cnt), 32'd1);
    hold(7'h4F, 4);
    measure(7'h5B, n);
    chk("t3_no_seq_err", 32'(seq_err), 32'd0);
    chk("t3_digit2", 32'(digit), 32'd2);
    hold(7'h5B, 4);

    // 4: glitch restarts the settle count
    hold(7'h00, 10);
    d0 = dv_seen;
    hold(7'h06, 3);
    hold(7'h4F, 8);
    hold(7'h4F, 6);
    chk("t4_pulses", 32'(dv_seen - d0), 32'd1);
    chk("t4_digit", 32'(digit), 32'd3);

    // 5: invalid then blank then glyph without sequence check
    d0 = dv_seen; g0 = ge_seen;
    hold(7'h01, 10);
    chk("t5_glyph_err", 32'(ge_seen - g0), 32'd1);
    chk("t5_no_dv", 32'(dv_seen - d0), 32'd0);
    chk("t5_digit_hold", 32'(digit), 32'd3);
    hold(7'h00, 10);
    chk("t5_blank", 32'(blank), 32'd1);
    s0 = se_seen;
    hold(7'h06, 10);
    chk("t5_no_seq", 32'(se_seen - s0), 32'd0);
    chk("t5_unblank", 32'(blank), 32'd0);

    // 6: saturation and clear
    for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h01 : 7'h02, 7);
    hold(7'h02, 8);
    chk("t6_saturated", 32'(err_cnt), 32'hFF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t6_cleared", 32'(err_cnt), 32'd0);

    // random episodes with occasional clear
    last = 0;
    for (int e = 0; e < 150; e++) begin
      n = int'($urandom_range(0, 9));
      if (n < 4) last = (last + STEP) % 16;
      else if (n < 7) last = int'($urandom_range(0, 15));
      if (n < 7) p = glyph[last];
      else if (n == 7) p = 7'h00;
      else p = 7'($urandom_range(0, 127));
      seg_in = p;
      repeat (int'($urandom_range(1, 9))) begin
        clr = ($urandom_range(0, 19) == 0);
        step();
      end
      clr = 1'b0;
    end

    // reset during SETTLE discards the pending glyph
    hold(7'h3F, 10);
    d0 = dv_seen;
    seg_in = 7'h66;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    repeat (3) step();
    chk("rst_no_strobe", 32'(dv_seen - d0), 32'd0);
    rst_n = 1'b1;
    measure(7'h66, n);
    chk("rst_relatency", 32'(n), 32'd6);
    chk("rst_digit", 32'(digit), 32'd4);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    hold(7'h66, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
